uart_receiver: RTL

//   Serial-to-parallel UART receive path: 8N1 frames on RxD become bytes presented on a

---
 rtl/uart_receiver.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path (8E1 when UART_RX_PARITY_EN is defined).
// RxD is double-synchronized, and each bit is sampled near its middle.
// Received bytes are presented on a valid/ready holding register.
// Framing, overrun and parity errors are reported as 1-clk pulses.
// The FSM state is available on the internal signal 'state' for probing.
module uart_receiver #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RxD,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  // Handshake: a byte transfers on any clk where rx_valid && rx_ready are both 1.
  // rx_data is held stable while rx_valid is 1. rx_ready is ignored while rx_valid is 0.

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t           state, state_next;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             start_edge;
  logic             cnt_clear, shift_en, commit, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_load, par_ok, par_bad;
  assign par_ok = ~^{shift, par_bit};
`endif

  assign start_edge = rx_prev & ~rx_s2;
  assign busy       = (state != S_IDLE);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RxD;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic and per-cycle strobes. The START bit is sampled at half a bit
  // time; every later bit is sampled one full bit time after the previous sample.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_load   = 1'b0;
    par_bad    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          cnt_clear  = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (clk_cnt == CNT_MID) begin
          cnt_clear  = 1'b1;
          state_next = rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_FULL) begin
          cnt_clear = 1'b1;
          shift_en  = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt == CNT_FULL) begin
          cnt_clear  = 1'b1;
          par_load   = 1'b1;
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt == CNT_FULL) begin
          cnt_clear = 1'b1;
          if (rx_s2) begin
            state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_ok) commit  = 1'b1;
            else        par_bad = 1'b1;
`else
            commit = 1'b1;
`endif
          end else begin
            frame_bad  = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s2) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bit-timing counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (cnt_clear || state == S_IDLE || state == S_BREAK) clk_cnt <= '0;
      else                                                  clk_cnt <= clk_cnt + CNT_W'(1);
      if (state == S_IDLE)  bit_cnt <= 3'd0;
      else if (shift_en)    bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)         shift   <= {rx_s2, shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit, checked together with the data bits at the stop-bit sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      par_bit <= 1'b0;
    else if (par_load) par_bit <= rx_s2;
  end

  // Parity error pulse, registered so it aligns with the commit/framing pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_err <= 1'b0;
    else          parity_err <= par_bad;
  end
`else
  assign parity_err = 1'b0;
`endif

  // Holding register. A commit while the register is full and not being consumed
  // drops the new byte and keeps the old one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      overrun_err <= commit && rx_valid && !rx_ready;
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
